gf180mcu_fd_sc_mcu9t5v0_and4_qual: RTL and testbench

//  Qualified 4-input coincidence detector; sequential companion to the and4 cells.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0_and4_qual.sv | 138 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0_and4_qual.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_and4_qual.sv
// Qualified 4-input coincidence detector: synchronizes A1..A4, requires HOLD
// consecutive coincident cycles (with EN) before asserting Z, pulses ZP on each
// rising Z and keeps a saturating count of those pulses.
module gf180mcu_fd_sc_mcu9t5v0_and4_qual #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD        = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A1,
  input  logic             A2,
  input  logic             A3,
  input  logic             A4,
  input  logic             EN,
  input  logic             CLR,
  output logic             Z,
  output logic             ZP,
  output logic [CNT_W-1:0] CNT,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int unsigned QW = $clog2(HOLD + 1);
  localparam logic [QW-1:0]    QLAST   = QW'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       sync_d [SYNC_STAGES];
  state_e           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             z_q, z_d;
  logic             zp_q, zp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coinc_c;
  logic             qual_c;

  // Supply pins carry no logic.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Synchronizer shift: stage 0 captures the raw inputs, later stages follow.
  always_comb begin
    sync_d[0] = {A4, A3, A2, A1};
    for (int j = 1; j < int'(SYNC_STAGES); j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign coinc_c = &sync_q[SYNC_STAGES-1];
  assign qual_c  = EN & coinc_c;

  // Qualification FSM next-state plus output/counter next values.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (qual_c) begin
          if (HOLD == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d = ARMING;
            qcnt_d  = QW'(1);
          end
        end
      end
      ARMING: begin
        if (!qual_c) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = ACTIVE;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      ACTIVE: begin
        if (!qual_c) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        qcnt_d  = '0;
      end
    endcase

    z_d  = (state_d == ACTIVE);
    zp_d = z_d & ~z_q;

    // A clear coinciding with a pulse keeps that pulse as the first event.
    if (CLR && zp_q) begin
      cnt_d = CNT_W'(1);
    end else if (CLR) begin
      cnt_d = '0;
    end else if (zp_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, synchronizer and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) begin
        sync_q[j] <= '0;
      end
      state_q <= IDLE;
      qcnt_q  <= '0;
      z_q     <= 1'b0;
      zp_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) begin
        sync_q[j] <= sync_d[j];
      end
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      z_q     <= z_d;
      zp_q    <= zp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Z   = z_q;
  assign ZP  = zp_q;
  assign CNT = cnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_and4_qual.sv
// Directed bench: u0 defaults, u1 with a 2-bit counter, u2 with HOLD=1.
module tb_gf180mcu_fd_sc_mcu9t5v0_and4_qual;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       en;
  logic       clr1;
  logic       clr0;
  wire        vdd;
  wire        vss;

  logic       z0, zp0, z1, zp1, z2, zp2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  int checks;
  int failures;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0_and4_qual u0 (
    .CLK(clk), .RST(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .EN(en), .CLR(clr0), .Z(z0), .ZP(zp0), .CNT(cnt0), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0_and4_qual #(.CNT_W(2)) u1 (
    .CLK(clk), .RST(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .EN(en), .CLR(clr1), .Z(z1), .ZP(zp1), .CNT(cnt1), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0_and4_qual #(.HOLD(1)) u2 (
    .CLK(clk), .RST(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .EN(en), .CLR(clr0), .Z(z2), .ZP(zp2), .CNT(cnt2), .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 4'hF; en = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (z0 !== 1'b0 || zp0 !== 1'b0 || cnt0 !== 8'd0 || z2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold edge=%0d z=%b zp=%b cnt=%0d z_h1=%b expected all 0", i, z0, zp0, cnt0, z2);
      end
    end
    rst = 1'b0;
  endtask

  // k=1 is edge N, the first edge sampling all inputs high after reset.
  task automatic test_qualify();
    logic       ez0, ezp0, ez2, ezp2;
    logic [7:0] ec0, ec2;
    for (int k = 1; k <= 7; k++) begin
      tick();
      ez0  = (k >= 6);
      ezp0 = (k == 6);
      ec0  = (k >= 7) ? 8'd1 : 8'd0;
      ez2  = (k >= 3);
      ezp2 = (k == 3);
      ec2  = (k >= 4) ? 8'd1 : 8'd0;
      checks++;
      if (z0 !== ez0 || zp0 !== ezp0 || cnt0 !== ec0) begin
        failures++;
        $display("FAIL qualify_hold4 k=%0d z=%b zp=%b cnt=%0d expected z=%b zp=%b cnt=%0d",
                 k, z0, zp0, cnt0, ez0, ezp0, ec0);
      end
      checks++;
      if (z2 !== ez2 || zp2 !== ezp2 || cnt2 !== ec2) begin
        failures++;
        $display("FAIL qualify_hold1 k=%0d z=%b zp=%b cnt=%0d expected z=%b zp=%b cnt=%0d",
                 k, z2, zp2, cnt2, ez2, ezp2, ec2);
      end
    end
  endtask

  task automatic test_release();
    a = 4'hD;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (z0 !== (k < 3)) begin
        failures++;
        $display("FAIL release_a2 k=%0d z=%b expected %b", k, z0, (k < 3));
      end
    end
    a = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (z0 !== (k == 6)) begin
        failures++;
        $display("FAIL requalify k=%0d z=%b expected %b", k, z0, (k == 6));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (z0 !== 1'b0) begin
      failures++;
      $display("FAIL release_en z=%b expected 0", z0);
    end
  endtask

  // A3 low only at edge N+2 gives one cycle of c=0 inside ARMING.
  task automatic test_restart();
    rst = 1'b1; a = 4'h0; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      a = (k == 3) ? 4'hB : 4'hF;
      tick();
      checks++;
      if (z0 !== (k == 9) || zp0 !== (k == 9)) begin
        failures++;
        $display("FAIL restart k=%0d z=%b zp=%b expected z=%b zp=%b", k, z0, zp0, (k == 9), (k == 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt;
    rst = 1'b1; a = 4'hF; en = 1'b0; clr1 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    for (int e = 1; e <= 5; e++) begin
      en = 1'b1;
      repeat (4) tick();
      checks++;
      if (z1 !== 1'b1 || zp1 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_pulse event=%0d z=%b zp=%b expected 1 1", e, z1, zp1);
      end
      en = 1'b0;
      tick();
      exp_cnt = (e >= 3) ? 2'd3 : 2'(e);
      checks++;
      if (cnt1 !== exp_cnt || zp1 !== 1'b0) begin
        failures++;
        $display("FAIL cnt_sat event=%0d cnt=%0d zp=%b expected cnt=%0d zp=0", e, cnt1, zp1, exp_cnt);
      end
    end
    en = 1'b1;
    repeat (4) tick();
    clr1 = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (cnt1 !== 2'd1) begin
      failures++;
      $display("FAIL clr_with_pulse cnt=%0d expected 1", cnt1);
    end
    tick();
    checks++;
    if (cnt1 !== 2'd0) begin
      failures++;
      $display("FAIL clr_alone cnt=%0d expected 0", cnt1);
    end
    clr1 = 1'b0;
  endtask

  task automatic test_rst_active();
    en = 1'b1;
    repeat (4) tick();
    checks++;
    if (z0 !== 1'b1) begin
      failures++;
      $display("FAIL active_before_rst z=%b expected 1", z0);
    end
    tick();
    checks++;
    if (cnt0 !== 8'd7 || z0 !== 1'b1 || zp0 !== 1'b0) begin
      failures++;
      $display("FAIL cnt_before_rst cnt=%0d z=%b zp=%b expected cnt=7 z=1 zp=0", cnt0, z0, zp0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (z0 !== 1'b0 || zp0 !== 1'b0 || cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL rst_in_active z=%b zp=%b cnt=%0d expected 0 0 0", z0, zp0, cnt0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (z0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_rst z=%b expected 0", z0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_qualify();
    test_release();
    test_restart();
    test_back_to_back();
    test_rst_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
